// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer
// Slew-limited duty / mode sequencer feeding the 3-channel PWM generator.
// Duty moves toward the host target by at most STEP LSBs every DIV PWM
// periods. A mode (sel) change first drains duty to 0, swaps sel in a
// dedicated one-cycle state, then ramps up to the new target.
module pwm_ramp_sequencer #(
  parameter int WIDTH = 8,
  parameter int STEP  = 4,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             period_tick,
  input  logic             load,
  input  logic [WIDTH-1:0] tgt_duty,
  input  logic             tgt_sel,
  output logic [WIDTH-1:0] duty_n,
  output logic             sel,
  output logic             load_ack,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } state_t;

  localparam int                 CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]   DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [WIDTH:0]     STEP_X   = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0]   STEP_W   = WIDTH'(STEP);

  state_t             state;
  logic [WIDTH-1:0]   tgt_d;
  logic               tgt_s;
  logic [CNT_W-1:0]   div_cnt;

  logic               step_evt;
  logic [WIDTH-1:0]   duty_goal;
  logic [WIDTH-1:0]   duty_step;

  // Move cur toward goal by at most STEP; the signed WIDTH+1 difference
  // keeps the direction and magnitude exact, so the result never overshoots
  // the goal and never wraps past 0 or 2**WIDTH-1.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] goal);
    logic signed [WIDTH:0] diff;
    logic        [WIDTH:0] mag;
    logic        [WIDTH-1:0] res;
    diff = $signed({1'b0, goal}) - $signed({1'b0, cur});
    res  = cur;
    if (diff[WIDTH]) begin
      mag = $unsigned(-diff);
      res = (mag > STEP_X) ? (cur - STEP_W) : goal;
    end else if (diff != '0) begin
      mag = $unsigned(diff);
      res = (mag > STEP_X) ? (cur + STEP_W) : goal;
    end
    return res;
  endfunction

  assign busy = (state != IDLE);

  // Step qualification and the next duty value toward the current goal
  always_comb begin
    step_evt  = period_tick && (div_cnt == DIV_LAST);
    duty_goal = (state == DRAIN) ? '0 : tgt_d;
    duty_step = step_toward(duty_n, duty_goal);
  end

  // Sequencer: divider, target capture, state transitions and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      duty_n   <= '0;
      sel      <= 1'b0;
      load_ack <= 1'b0;
      done     <= 1'b0;
      tgt_d    <= '0;
      tgt_s    <= 1'b0;
      div_cnt  <= '0;
    end else if (!ena) begin
      load_ack <= 1'b0;
      done     <= 1'b0;
    end else begin
      load_ack <= load;
      done     <= 1'b0;
      if (period_tick) begin
        div_cnt <= step_evt ? '0 : div_cnt + 1'b1;
      end
      if (load) begin
        // A load overrides any step or swap on this edge
        tgt_d <= tgt_duty;
        tgt_s <= tgt_sel;
        if (tgt_sel != sel) begin
          state <= DRAIN;
        end else if (tgt_duty == duty_n) begin
          state <= IDLE;
          done  <= 1'b1;
        end else begin
          state <= RAMP;
        end
      end else begin
        case (state)
          IDLE: begin
          end
          RAMP: begin
            if (step_evt) begin
              duty_n <= duty_step;
              if (duty_step == tgt_d) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
          end
          DRAIN: begin
            if (duty_n == '0) begin
              state <= SWAP;
            end else if (step_evt) begin
              duty_n <= duty_step;
            end
          end
          SWAP: begin
            // duty_n is 0 here, so the mode flips with no pulse in flight
            sel     <= tgt_s;
            div_cnt <= '0;
            if (tgt_d == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= RAMP;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Testbench for pwm_ramp_sequencer: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural model of the sequencer.
module tb_pwm_ramp_sequencer;

  localparam int WIDTH = 8;
  localparam int STEP  = 4;
  localparam int DIV   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             period_tick = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] tgt_duty = '0;
  logic             tgt_sel = 1'b0;
  logic [WIDTH-1:0] duty_n;
  logic             sel;
  logic             load_ack;
  logic             busy;
  logic             done;

  pwm_ramp_sequencer #(.WIDTH(WIDTH), .STEP(STEP), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .period_tick(period_tick),
    .load(load), .tgt_duty(tgt_duty), .tgt_sel(tgt_sel),
    .duty_n(duty_n), .sel(sel), .load_ack(load_ack), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase 0 = settled, 1 = ramping to target,
  // 2 = draining to zero before a mode change, 3 = mode swap cycle
  int m_duty, m_sel, m_ack, m_done, m_phase, m_td, m_ts, m_div;
  int done_seen;
  logic prev_sel;
  int saved;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int move(input int cur, input int goal);
    if (goal > cur) return (goal - cur > STEP) ? cur + STEP : goal;
    if (goal < cur) return (cur - goal > STEP) ? cur - STEP : goal;
    return cur;
  endfunction

  task automatic model_reset();
    m_duty = 0; m_sel = 0; m_ack = 0; m_done = 0;
    m_phase = 0; m_td = 0; m_ts = 0; m_div = 0;
  endtask

  // Advance the model by one clock edge with the given inputs
  task automatic model_step(input bit e, input bit t, input bit l, input int td, input int ts);
    bit wrap;
    if (!e) begin
      m_ack = 0;
      m_done = 0;
      return;
    end
    wrap = t && (m_div == DIV - 1);
    m_ack = l;
    m_done = 0;
    if (t) m_div = wrap ? 0 : m_div + 1;
    if (l) begin
      m_td = td;
      m_ts = ts;
      if (ts != m_sel) m_phase = 2;
      else if (td == m_duty) begin m_phase = 0; m_done = 1; end
      else m_phase = 1;
    end else if (m_phase == 1) begin
      if (wrap) begin
        m_duty = move(m_duty, m_td);
        if (m_duty == m_td) begin m_phase = 0; m_done = 1; end
      end
    end else if (m_phase == 2) begin
      if (m_duty == 0) m_phase = 3;
      else if (wrap) m_duty = move(m_duty, 0);
    end else if (m_phase == 3) begin
      m_sel = m_ts;
      m_div = 0;
      if (m_td == 0) begin m_phase = 0; m_done = 1; end
      else m_phase = 1;
    end
  endtask

  task automatic compare_all();
    check("duty_n", 32'(duty_n), 32'(m_duty));
    check("sel", 32'(sel), 32'(m_sel));
    check("load_ack", 32'(load_ack), 32'(m_ack));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("done", 32'(done), 32'(m_done));
  endtask

  // One clock: compare at the falling edge, then drive the next inputs
  task automatic cyc(input bit e, input bit t, input bit l, input int td, input int ts);
    @(negedge clk);
    compare_all();
    if (done) done_seen++;
    if (sel !== prev_sel) check("sel_at_zero", 32'(duty_n), 32'd0);
    prev_sel = sel;
    ena = e;
    period_tick = t;
    load = l;
    tgt_duty = WIDTH'(td);
    tgt_sel = ts[0];
    model_step(e, t, l, td, ts);
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
    end
  endtask

  task automatic mid_cycle_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_duty", 32'(duty_n), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack", 32'(load_ack), 32'd0);
    model_reset();
    prev_sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b0;
    period_tick = 1'b0;
    load = 1'b0;
    model_step(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    prev_sel = 1'b0;
    done_seen = 0;
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Idle after reset: ticks alone do nothing visible
    run_ticks(2);
    check("idle_duty", 32'(duty_n), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Ramp up 0 -> 20
    done_seen = 0;
    cyc(1, 0, 1, 20, 0);
    run_ticks(10);
    cyc(1, 0, 0, 0, 0);
    check("ramp20_duty", 32'(duty_n), 32'd20);
    check("ramp20_done_count", 32'(done_seen), 32'd1);

    // Back down to 0, then partial last step up to 10, then down to 3
    cyc(1, 0, 1, 0, 0);
    run_ticks(12);
    check("down0_duty", 32'(duty_n), 32'd0);
    cyc(1, 0, 1, 10, 0);
    run_ticks(8);
    check("partial10_duty", 32'(duty_n), 32'd10);
    cyc(1, 0, 1, 3, 0);
    run_ticks(6);
    check("partial3_duty", 32'(duty_n), 32'd3);

    // Retarget during drain cancels the mode change
    cyc(1, 0, 1, 30, 0);
    run_ticks(16);
    cyc(1, 0, 1, 50, 1);
    run_ticks(2);
    check("drain_busy", 32'(busy), 32'd1);
    cyc(1, 0, 1, 8, 0);
    run_ticks(12);
    check("retarget_sel", 32'(sel), 32'd0);
    check("retarget_duty", 32'(duty_n), 32'd8);

    // Load on the same edge as ticks: no step on those edges
    cyc(1, 1, 1, 60, 0);
    cyc(1, 1, 1, 60, 0);
    cyc(1, 0, 0, 0, 0);
    check("no_step_on_load", 32'(duty_n), 32'd8);
    run_ticks(30);
    check("ramp60_duty", 32'(duty_n), 32'd60);

    // Mode change 20/sel0 -> 40/sel1
    cyc(1, 0, 1, 20, 0);
    run_ticks(25);
    done_seen = 0;
    cyc(1, 0, 1, 40, 1);
    run_ticks(40);
    check("mode_sel", 32'(sel), 32'd1);
    check("mode_duty", 32'(duty_n), 32'd40);
    check("mode_done_count", 32'(done_seen), 32'd1);

    // Freeze with ena=0 mid-ramp
    cyc(1, 0, 1, 100, 1);
    run_ticks(3);
    saved = int'(duty_n);
    repeat (5) begin
      cyc(0, 1, 1, 7, 0);
      cyc(0, 0, 0, 0, 0);
    end
    cyc(1, 0, 0, 0, 0);
    check("freeze_duty", 32'(duty_n), 32'(saved));
    check("freeze_busy", 32'(busy), 32'd1);
    run_ticks(40);
    check("resume_duty", 32'(duty_n), 32'd100);

    // Asynchronous reset mid-ramp; nothing resumes afterwards
    cyc(1, 0, 1, 200, 1);
    run_ticks(3);
    mid_cycle_reset();
    run_ticks(4);
    check("post_rst_duty", 32'(duty_n), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      int td, r;
      bit e, t, l, ts;
      e = ($urandom_range(0, 9) != 0);
      t = ($urandom_range(0, 9) < 4);
      l = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 9);
      if (r == 0) td = 0;
      else if (r == 1) td = (1 << WIDTH) - 1;
      else if (r == 2) td = m_duty;
      else td = $urandom_range(0, (1 << WIDTH) - 1);
      ts = (m_sel != 0) ^ ($urandom_range(0, 3) == 0);
      cyc(e, t, l, td, ts);
    end
    cyc(1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
